bcd_seg_scan: RTL

//  Consumes the 2-digit BCD sum and decimal carry from the BCD adder stage.

---
 rtl/bcd_disp_pkg.sv | 30 +++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/bcd_seg_scan.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the BCD multiplexed display scanner.
package bcd_disp_pkg;

    // Digit slot currently being driven, in scan order.
    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_HUND = 2'd2
    } digit_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // True when the nibble is not a legal BCD digit.
    function automatic logic nib_bad(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-BCD shows 'E'.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one nibble.
    always_comb begin
        seg = SEG_E;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// 3-digit multiplexed common-anode display driver for a BCD sum plus carry.
// Snapshots the value on load and scans hundreds/tens/ones with a blanking gap
// at the start of every slot so the previous digit cannot ghost onto the next.
module bcd_seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    input  logic       carry_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg_n,
    output logic [2:0] an_n,
    output logic       err
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYCLES);

    generate
        if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
            $error("bcd_seg_scan: need REFRESH_DIV >= 2 and 0 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    logic [7:0]    snap;
    logic          snap_c;
    logic [CW-1:0] cnt;
    digit_e        state, state_nxt;
    logic          wrap;

    logic [3:0]    nib_p0;
    logic          blank_p0;
    logic [2:0]    an_sel_p0;
    logic [6:0]    dec_p0;
    logic [6:0]    seg_p0;
    logic [2:0]    an_p0;

    assign wrap = (cnt == CNT_LAST);

    // Snapshot capture and sticky non-BCD flag; only a new load changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap   <= '0;
            snap_c <= 1'b0;
            err    <= 1'b0;
        end else if (load) begin
            snap   <= bcd_in;
            snap_c <= carry_in;
            err    <= nib_bad(bcd_in[7:4]) || nib_bad(bcd_in[3:0]);
        end
    end

    // Per-slot prescaler, wrapping after REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= wrap ? '0 : cnt + 1'b1;
    end

    // Digit slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DIG_ONES;
        else        state <= state_nxt;
    end

    // Slot sequencing plus digit select and leading-zero blanking for this slot.
    always_comb begin
        state_nxt = state;
        nib_p0    = snap[3:0];
        blank_p0  = 1'b0;
        an_sel_p0 = 3'b110;
        case (state)
            DIG_ONES: begin
                if (wrap) state_nxt = DIG_TENS;
                nib_p0    = snap[3:0];
                an_sel_p0 = 3'b110;
            end
            DIG_TENS: begin
                if (wrap) state_nxt = DIG_HUND;
                nib_p0    = snap[7:4];
                // A zero tens is only leading when there is no carry; bad nibbles are never zero.
                blank_p0  = blank_lz && !snap_c && (snap[7:4] == 4'd0);
                an_sel_p0 = 3'b101;
            end
            DIG_HUND: begin
                if (wrap) state_nxt = DIG_ONES;
                nib_p0    = {3'b000, snap_c};
                blank_p0  = blank_lz && !snap_c;
                an_sel_p0 = 3'b011;
            end
            default: begin
                state_nxt = DIG_ONES;
            end
        endcase
    end

    bcd_to_seg u_dec (
        .nib (nib_p0),
        .seg (dec_p0)
    );

    assign seg_p0 = blank_p0 ? SEG_OFF : dec_p0;
    assign an_p0  = (blank_p0 || cnt < BLANK_V) ? 3'b111 : an_sel_p0;

    // ---- stage p0 -> registered display outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_OFF;
            an_n  <= 3'b111;
        end else begin
            seg_n <= seg_p0;
            an_n  <= an_p0;
        end
    end

endmodule
